// File: rtl/lsu_store_router.sv
// Store-path router: decodes LSU stores into DMEM, LED and 7-seg regions, writes DMEM
// directly and posts peripheral stores into a small write FIFO drained by valid/ready.
module lsu_store_router #(
    parameter logic [15:0] DMEM_BASE  = 16'h0800,
    parameter logic [15:0] DMEM_SIZE  = 16'h0800,
    parameter logic [15:0] LED_BASE   = 16'h1C00,
    parameter logic [15:0] LED_SIZE   = 16'd16,
    parameter logic [15:0] SEG_BASE   = 16'h1E00,
    parameter logic [15:0] SEG_SIZE   = 16'd8,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_wren,
    input  logic [31:0] i_lsu_addr,
    input  logic [1:0]  i_st_size,
    input  logic [31:0] i_st_data,
    output logic        o_stall,
    output logic        o_dmem_wren,
    output logic [3:0]  o_dmem_bmask,
    output logic [31:0] o_dmem_wdata,
    output logic        o_io_valid,
    input  logic        i_io_ready,
    output logic        o_io_sel,
    output logic [7:0]  o_io_offset,
    output logic [3:0]  o_io_bmask,
    output logic [31:0] o_io_wdata,
    output logic        o_misalign,
    output logic        o_unmapped
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [7:0] LED_OMASK = 8'(LED_SIZE - 16'd1);
    localparam logic [7:0] SEG_OMASK = 8'(SEG_SIZE - 16'd1);

    typedef struct packed {
        logic        sel;
        logic [7:0]  offset;
        logic [3:0]  bmask;
        logic [31:0] wdata;
    } io_entry_t;

    logic [15:0] w_addr;
    logic [1:0]  w_lsb;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;
    logic        w_mis;
    logic        w_ok;
    logic        w_dmem_hit, w_led_hit, w_seg_hit;
    logic        w_push_req, w_push, w_pop, w_full;
    logic [7:0]  w_offset;
    io_entry_t   w_entry, w_head;
    logic        w_unused_addr;

    io_entry_t   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic        r_misalign, r_unmapped;

    assign w_addr        = i_lsu_addr[15:0];
    assign w_lsb         = w_addr[1:0];
    assign w_unused_addr = ^i_lsu_addr[31:16];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_mask  = 4'b0000;
        w_wdata = 32'h0;
        w_mis   = 1'b1;
        case (i_st_size)
            2'b00: begin
                w_mask  = 4'b0001 << w_lsb;
                w_wdata = {4{i_st_data[7:0]}};
                w_mis   = 1'b0;
            end
            2'b01: begin
                w_mask  = 4'b0011 << w_lsb;
                w_wdata = {2{i_st_data[15:0]}};
                w_mis   = w_lsb[0];
            end
            2'b10: begin
                w_mask  = 4'b1111;
                w_wdata = i_st_data;
                w_mis   = |w_lsb;
            end
            default: ;
        endcase
    end

    assign w_dmem_hit = (w_addr & ~(DMEM_SIZE - 16'd1)) == DMEM_BASE;
    assign w_led_hit  = (w_addr & ~(LED_SIZE - 16'd1)) == LED_BASE;
    assign w_seg_hit  = (w_addr & ~(SEG_SIZE - 16'd1)) == SEG_BASE;
    assign w_ok       = i_mem_wren & ~w_mis;

    assign w_offset = {w_addr[7:2] & (w_seg_hit ? SEG_OMASK[7:2] : LED_OMASK[7:2]), 2'b00};
    assign w_entry  = '{sel: w_seg_hit, offset: w_offset, bmask: w_mask, wdata: w_wdata};

    assign o_dmem_wren  = w_ok & w_dmem_hit;
    assign o_dmem_bmask = o_dmem_wren ? w_mask : 4'b0000;
    assign o_dmem_wdata = i_mem_wren ? w_wdata : 32'h0;

    // A full FIFO still accepts a store when its head leaves in the same cycle.
    assign w_full     = r_count == CW'(FIFO_DEPTH);
    assign w_pop      = o_io_valid & i_io_ready;
    assign w_push_req = w_ok & (w_led_hit | w_seg_hit);
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign o_stall    = w_push_req & ~w_push;

    assign w_head      = r_mem[r_rd_ptr];
    assign o_io_valid  = r_count != '0;
    assign o_io_sel    = w_head.sel;
    assign o_io_offset = w_head.offset;
    assign o_io_bmask  = w_head.bmask;
    assign o_io_wdata  = w_head.wdata;
    assign o_misalign  = r_misalign;
    assign o_unmapped  = r_unmapped;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
            r_unmapped <= 1'b0;
        end else begin
            r_misalign <= i_mem_wren & w_mis;
            r_unmapped <= w_ok & ~(w_dmem_hit | w_led_hit | w_seg_hit);
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; the count alone decides which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

endmodule

// File: tb/tb_lsu_store_router.sv
// Self-checking bench for lsu_store_router: directed scenarios then random stores,
// compared against a queue-based model of the store-routing rules.
module tb_lsu_store_router;

    localparam int DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_mem_wren = 1'b0;
    logic [31:0] i_lsu_addr = '0;
    logic [1:0]  i_st_size = '0;
    logic [31:0] i_st_data = '0;
    logic        i_io_ready = 1'b0;
    logic        o_stall, o_dmem_wren, o_io_valid, o_io_sel, o_misalign, o_unmapped;
    logic [3:0]  o_dmem_bmask, o_io_bmask;
    logic [31:0] o_dmem_wdata, o_io_wdata;
    logic [7:0]  o_io_offset;

    lsu_store_router dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_mem_wren(i_mem_wren),
        .i_lsu_addr(i_lsu_addr), .i_st_size(i_st_size), .i_st_data(i_st_data),
        .o_stall(o_stall), .o_dmem_wren(o_dmem_wren), .o_dmem_bmask(o_dmem_bmask),
        .o_dmem_wdata(o_dmem_wdata), .o_io_valid(o_io_valid), .i_io_ready(i_io_ready),
        .o_io_sel(o_io_sel), .o_io_offset(o_io_offset), .o_io_bmask(o_io_bmask),
        .o_io_wdata(o_io_wdata), .o_misalign(o_misalign), .o_unmapped(o_unmapped)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        sel;
        logic [7:0]  offset;
        logic [3:0]  bmask;
        logic [31:0] wdata;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   exp_mis = 1'b0;
    bit   exp_unm = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Region index: 0 DMEM, 1 LED, 2 SEG, -1 none.
    function automatic int region_of(input logic [15:0] a);
        int ai = int'(a);
        if (ai >= 'h0800 && ai < 'h1000) return 0;
        if (ai >= 'h1C00 && ai < 'h1C10) return 1;
        if (ai >= 'h1E00 && ai < 'h1E08) return 2;
        return -1;
    endfunction

    function automatic int region_base(input int r);
        return (r == 1) ? 'h1C00 : 'h1E00;
    endfunction

    // Drive one cycle of inputs (called on a falling edge); check, then advance the model.
    task automatic step(input bit wren, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] data, input bit ready);
        logic [15:0] a;
        int nb, rg, lane0;
        bit mis, io, pop, push, stall;
        logic [3:0] mask;
        logic [31:0] rep;
        ent_t e;
        i_mem_wren = wren; i_lsu_addr = addr; i_st_size = size;
        i_st_data = data;  i_io_ready = ready;
        #1;
        check("misalign", o_misalign, exp_mis);
        check("unmapped", o_unmapped, exp_unm);

        a     = addr[15:0];
        nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
        mis   = wren && (nb == 0 || (int'(a) % nb) != 0);
        rg    = region_of(a);
        lane0 = int'(a) % 4;
        mask  = '0;
        rep   = '0;
        if (nb != 0) begin
            for (int k = 0; k < nb; k++) if (lane0 + k < 4) mask[lane0 + k] = 1'b1;
            for (int i = 0; i < 4; i++) rep[8*i +: 8] = data[8*(i % nb) +: 8];
        end

        pop   = (q.size() != 0) && ready;
        io    = wren && !mis && (rg == 1 || rg == 2);
        stall = io && (q.size() == DEPTH) && !pop;
        push  = io && !stall;

        check("dmem_wren", o_dmem_wren, wren && !mis && rg == 0);
        if (wren && !mis && rg == 0) check("dmem_bmask", o_dmem_bmask, mask);
        if (!wren) check("dmem_bmask_idle", o_dmem_bmask, 0);
        if (wren && nb != 0) check("dmem_wdata", o_dmem_wdata, rep);
        if (!wren) check("dmem_wdata_idle", o_dmem_wdata, 0);
        check("stall", o_stall, stall);
        check("io_valid", o_io_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("io_sel", o_io_sel, q[0].sel);
            check("io_offset", o_io_offset, q[0].offset);
            check("io_bmask", o_io_bmask, q[0].bmask);
            check("io_wdata", o_io_wdata, q[0].wdata);
        end

        @(posedge i_clk);
        if (pop) void'(q.pop_front());
        if (push) begin
            e.sel    = (rg == 2);
            e.offset = 8'((int'(a) - region_base(rg)) & ~3);
            e.bmask  = mask;
            e.wdata  = rep;
            q.push_back(e);
        end
        exp_mis = mis;
        exp_unm = wren && !mis && rg < 0;
        @(negedge i_clk);
    endtask

    task automatic idle(input bit ready);
        step(1'b0, 32'h0, 2'b00, 32'h0, ready);
    endtask

    task automatic do_reset();
        i_mem_wren = 1'b0;
        i_io_ready = 1'b0;
        #2 i_reset = 1'b0;
        #1;
        check("rst_io_valid", o_io_valid, 0);
        check("rst_misalign", o_misalign, 0);
        check("rst_unmapped", o_unmapped, 0);
        q.delete();
        exp_mis = 1'b0;
        exp_unm = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
    endtask

    initial begin
        int r, sz;
        logic [31:0] ad;
        // Reset state and idle comb outputs
        @(negedge i_clk);
        do_reset();
        idle(1'b0);

        // 1: word store to DMEM
        step(1'b1, 32'h0000_0804, 2'b10, 32'hDEAD_BEEF, 1'b0);
        idle(1'b0);

        // 2: byte store to LED, appears next cycle, then drains
        step(1'b1, 32'h0000_1C03, 2'b00, 32'h0000_00A5, 1'b0);
        check("t2_valid", o_io_valid, 1);
        check("t2_wdata", o_io_wdata, 32'hA5A5_A5A5);
        check("t2_bmask", o_io_bmask, 4'b1000);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // 3: misaligned half store to SEG
        step(1'b1, 32'h0000_1E05, 2'b01, 32'h1234_5678, 1'b0);
        check("t3_pulse", o_misalign, 1);
        idle(1'b0);
        idle(1'b0);

        // 4/5: fill FIFO, fifth store stalls, then held store goes in alongside a pop
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h0000_1E00 + 32'(4 * (i % 2)), 2'b10, 32'hC0DE_0000 + 32'(i), 1'b0);
        step(1'b1, 32'h0000_1E00, 2'b10, 32'hC0DE_0004, 1'b0);
        check("t4_model_full", 32'(q.size()), DEPTH);
        step(1'b1, 32'h0000_1E00, 2'b10, 32'hC0DE_0004, 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b1);

        // 6: unmapped store, then reset with three entries queued
        step(1'b1, 32'h0000_3000, 2'b10, 32'h1111_2222, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h0000_1C04 + 32'(4 * i), 2'b10, 32'hBEEF_0000 + 32'(i), 1'b0);
        do_reset();
        idle(1'b1);

        // Random stores across all regions with random back-pressure
        for (int n = 0; n < 400; n++) begin
            r  = int'($urandom_range(0, 3));
            sz = int'($urandom_range(0, 9));
            case (r)
                0: ad = 32'h0000_0800 + 32'($urandom_range(0, 'h7FF));
                1: ad = 32'h0000_1C00 + 32'($urandom_range(0, 15));
                2: ad = 32'h0000_1E00 + 32'($urandom_range(0, 7));
                default: ad = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) ad[31:16] = 16'($urandom);
            if (sz < 3) ad[0] = 1'b0;
            if (sz < 5) ad[1] = 1'b0;
            step($urandom_range(0, 9) < 7, ad, 2'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 8; i++) idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
